pick_sched: RTL and testbench

- Scheduler/controller for the PICK actor. Selects one of FLUX input FIFOs per firing and forwards its tokens to a single output FIFO, prefixed with the channel tag.
- Two modes:
  - Cyclic (CSDF-style): fixed round-robin with a burst of BURST tokens per channel.
  - Control-driven (DDF-style): the select index is read from a control (NDA) FIFO.
- Sits between the per-channel input FIFOs and the downstream FIFO of the PICK wrappers.

---
 rtl/pick_sched_pkg.sv | 11 +
 rtl/pick_rr_cnt.sv | 46 ++++
 rtl/pick_sched.sv | 112 +++++++++++
 tb/tb_pick_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pick_sched_pkg.sv
// Shared types for the PICK scheduler: FSM states, firing modes and tag sizing.
package pick_pkg;
   typedef enum logic {S_GET = 1'b0, S_XFER = 1'b1} state_e;

   localparam logic MODE_CSDF = 1'b0;
   localparam logic MODE_DDF  = 1'b1;

   function automatic int tag_w(input int flux);
      return (flux > 1) ? $clog2(flux) : 1;
   endfunction
endpackage

// File: rtl/pick_rr_cnt.sv
// Round-robin channel pointer plus burst counter for cyclic firings.
// load clears the burst count; adv counts a transfer and steps rr after the last one.
module pick_rr_cnt import pick_pkg::*; #(
   parameter int FLUX      = 2,
   parameter int BURST     = 1,
   parameter int TAG_WIDTH = tag_w(FLUX)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 adv,
   output logic [TAG_WIDTH-1:0] rr,
   output logic                 last
);
   localparam int CW = $clog2(BURST + 1);
   localparam logic [CW-1:0]        CNT_LAST = CW'(BURST - 1);
   localparam logic [TAG_WIDTH-1:0] RR_MAX   = TAG_WIDTH'(FLUX - 1);

   logic [CW-1:0]        cnt_q, cnt_d;
   logic [TAG_WIDTH-1:0] rr_q, rr_d;

   assign rr   = rr_q;
   assign last = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      rr_d  = rr_q;
      if (load) begin
         cnt_d = '0;
      end else if (adv) begin
         cnt_d = cnt_q + 1'b1;
         // Wrap at FLUX-1, not at the tag width's power of two.
         if (last) rr_d = (rr_q == RR_MAX) ? '0 : rr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         rr_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         rr_q  <= rr_d;
      end
   end
endmodule

// File: rtl/pick_sched.sv
// PICK actor scheduler: per firing picks one input FIFO (round-robin bursts or control token) and forwards {tag,payload}.
// Transfers stall while the selected FIFO is empty or the output is full; PICK_SCHED_STATS_EN adds per-channel pop counters.
module pick_sched import pick_pkg::*; #(
   parameter int FLUX       = 2,
   parameter int DATA_WIDTH = 8,
   parameter int TAG_WIDTH  = tag_w(FLUX),
   parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH,
   parameter int BURST      = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mode,
   input  logic                       ctrl_empty,
   input  logic [TAG_WIDTH-1:0]       ctrl_dataout,
   output logic                       ctrl_read,
   input  logic [FLUX-1:0]            in_empty,
   input  logic [FLUX*DATA_WIDTH-1:0] in_dataout,
   output logic [FLUX-1:0]            in_read,
   input  logic                       out_full,
   output logic [WIDTH-1:0]           out_datain,
   output logic                       out_write,
   output logic                       busy,
   output logic                       err_sel
`ifdef PICK_SCHED_STATS_EN
  ,output logic [FLUX*16-1:0]         tok_cnt
`endif
);
   state_e               state_q;
   logic [TAG_WIDTH-1:0] sel_q;
   logic                 mode_q;
   logic                 err_q;
   logic [TAG_WIDTH-1:0] rr;
   logic                 last;
   logic                 fire, ctrl_ok, load, adv;
   logic [DATA_WIDTH-1:0] words [FLUX];

   always_comb begin
      for (int i = 0; i < FLUX; i++) words[i] = in_dataout[i*DATA_WIDTH +: DATA_WIDTH];
   end

   assign ctrl_ok   = int'(ctrl_dataout) < FLUX;
   assign fire      = (state_q == S_XFER) && !in_empty[sel_q] && !out_full;
   assign load      = (state_q == S_GET) && ((mode == MODE_CSDF) || (!ctrl_empty && ctrl_ok));
   // Only cyclic firings consume the burst count and step the round-robin pointer.
   assign adv       = fire && (mode_q == MODE_CSDF);
   assign ctrl_read = (state_q == S_GET) && (mode == MODE_DDF) && !ctrl_empty;
   assign out_write = fire;
   assign out_datain = fire ? {sel_q, words[sel_q]} : '0;
   assign busy      = (state_q == S_XFER);
   assign err_sel   = err_q;

   always_comb begin
      for (int i = 0; i < FLUX; i++) in_read[i] = fire && (sel_q == TAG_WIDTH'(i));
   end

   pick_rr_cnt #(.FLUX(FLUX), .BURST(BURST), .TAG_WIDTH(TAG_WIDTH)) u_rr_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .adv  (adv),
      .rr   (rr),
      .last (last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_GET;
         sel_q   <= '0;
         mode_q  <= MODE_CSDF;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_GET: begin
               if (mode == MODE_CSDF) begin
                  sel_q   <= rr;
                  mode_q  <= MODE_CSDF;
                  state_q <= S_XFER;
               end else if (!ctrl_empty) begin
                  if (ctrl_ok) begin
                     sel_q   <= ctrl_dataout;
                     mode_q  <= MODE_DDF;
                     state_q <= S_XFER;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_XFER: begin
               if (fire && ((mode_q == MODE_DDF) || last)) state_q <= S_GET;
            end
            default: state_q <= S_GET;
         endcase
      end
   end

`ifdef PICK_SCHED_STATS_EN
   logic [15:0] tok_q [FLUX];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FLUX; i++) tok_q[i] <= '0;
      end else begin
         for (int i = 0; i < FLUX; i++) if (in_read[i]) tok_q[i] <= tok_q[i] + 16'd1;
      end
   end

   always_comb begin
      tok_cnt = '0;
      for (int i = 0; i < FLUX; i++) tok_cnt[i*16 +: 16] = tok_q[i];
   end
`endif
endmodule

// File: tb/tb_pick_sched.sv
// Bench for pick_sched: a FIFO-queue reference model checked every cycle, plus directed literal checks.
module tb_pick_sched;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: FLUX=2, BURST=2
   logic        rst, mode, ctrl_empty, ctrl_read, out_full, out_write, busy, err_sel;
   logic [0:0]  ctrl_dataout;
   logic [1:0]  in_empty, in_read;
   logic [15:0] in_dataout;
   logic [8:0]  out_datain;
   // DUT B: FLUX=3, BURST=1
   logic        rst_b, b_mode, b_ctrl_empty, b_ctrl_read, b_out_full, b_out_write, b_busy, b_err_sel;
   logic [1:0]  b_ctrl_dataout;
   logic [2:0]  b_in_empty, b_in_read;
   logic [23:0] b_in_dataout;
   logic [9:0]  b_out_datain;
`ifdef PICK_SCHED_STATS_EN
   logic [31:0] tok_cnt;
   logic [47:0] b_tok_cnt;
`endif

   pick_sched #(.FLUX(2), .DATA_WIDTH(8), .BURST(2)) u_dut (
      .clk(clk), .rst(rst), .mode(mode), .ctrl_empty(ctrl_empty), .ctrl_dataout(ctrl_dataout),
      .ctrl_read(ctrl_read), .in_empty(in_empty), .in_dataout(in_dataout), .in_read(in_read),
      .out_full(out_full), .out_datain(out_datain), .out_write(out_write), .busy(busy), .err_sel(err_sel)
`ifdef PICK_SCHED_STATS_EN
     ,.tok_cnt(tok_cnt)
`endif
   );

   pick_sched #(.FLUX(3), .DATA_WIDTH(8), .BURST(1)) u_dut3 (
      .clk(clk), .rst(rst_b), .mode(b_mode), .ctrl_empty(b_ctrl_empty), .ctrl_dataout(b_ctrl_dataout),
      .ctrl_read(b_ctrl_read), .in_empty(b_in_empty), .in_dataout(b_in_dataout), .in_read(b_in_read),
      .out_full(b_out_full), .out_datain(b_out_datain), .out_write(b_out_write), .busy(b_busy), .err_sel(b_err_sel)
`ifdef PICK_SCHED_STATS_EN
     ,.tok_cnt(b_tok_cnt)
`endif
   );

   int n_chk = 0, n_err = 0;
   logic [7:0] q [2][$];
   int cq [$];
   int wr_log [$];
   int m_busy, m_sel, m_rem, m_ddf, m_rr, m_err;
   int m_cnt [2];
   int n_ctrl_rd, wr_pat;
   bit rnd_en, tog_full;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < 2; i++) begin
         in_empty[i] = (q[i].size() == 0);
         in_dataout[i*8 +: 8] = (q[i].size() != 0) ? q[i][0] : 8'h00;
      end
      ctrl_empty   = (cq.size() == 0);
      ctrl_dataout = (cq.size() != 0) ? 1'(cq[0]) : 1'b0;
   endtask

   task automatic model_reset();
      m_busy = 0; m_sel = 0; m_rem = 0; m_ddf = 0; m_rr = 0; m_err = 0;
      m_cnt[0] = 0; m_cnt[1] = 0;
   endtask

   // Called at a falling edge: check this cycle, advance across the rising edge, return at next falling edge.
   task automatic step();
      int e_fire, e_crd, e_dat, t;
      drive();
      #1;
      e_fire = (m_busy != 0 && q[m_sel].size() > 0 && !out_full) ? 1 : 0;
      e_crd  = (m_busy == 0 && mode && cq.size() > 0) ? 1 : 0;
      e_dat  = e_fire ? ((m_sel << 8) | int'(q[m_sel][0])) : 0;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("ctrl_read", 32'(ctrl_read), 32'(e_crd));
      chk("out_write", 32'(out_write), 32'(e_fire));
      chk("in_read", 32'(in_read), e_fire ? 32'(1 << m_sel) : 32'd0);
      chk("out_datain", 32'(out_datain), 32'(e_dat));
      chk("err_sel", 32'(err_sel), 32'(m_err));
`ifdef PICK_SCHED_STATS_EN
      chk("tok_cnt0", 32'(tok_cnt[15:0]), 32'(m_cnt[0]));
      chk("tok_cnt1", 32'(tok_cnt[31:16]), 32'(m_cnt[1]));
`endif
      if (out_write) wr_log.push_back(int'(out_datain));
      if (ctrl_read) n_ctrl_rd++;
      wr_pat = (wr_pat << 1) | int'(out_write);
      @(posedge clk);
      #1;
      if (m_busy == 0) begin
         if (!mode) begin
            m_sel = m_rr; m_rem = 2; m_ddf = 0; m_busy = 1;
         end else if (cq.size() > 0) begin
            t = cq.pop_front();
            if (t < 2) begin m_sel = t; m_rem = 1; m_ddf = 1; m_busy = 1; end
            else m_err = 1;
         end
      end else if (e_fire != 0) begin
         void'(q[m_sel].pop_front());
         m_cnt[m_sel] = (m_cnt[m_sel] + 1) % 65536;
         m_rem--;
         if (m_rem == 0) begin
            m_busy = 0;
            if (m_ddf == 0) m_rr = (m_rr + 1) % 2;
         end
      end
      if (tog_full) out_full = !out_full;
      if (rnd_en) begin
         out_full = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) mode = !mode;
         for (int i = 0; i < 2; i++)
            if (q[i].size() < 4 && $urandom_range(0, 2) == 0) q[i].push_back(8'($urandom));
         if (cq.size() < 3 && $urandom_range(0, 2) == 0) cq.push_back(int'($urandom_range(0, 1)));
      end
      @(negedge clk);
   endtask

   initial begin
      int exp1 [6];
      rst = 1'b0; rst_b = 1'b0; mode = 1'b0; out_full = 1'b0;
      rnd_en = 0; tog_full = 0; n_ctrl_rd = 0; wr_pat = 0;
      b_mode = 1'b1; b_ctrl_empty = 1'b1; b_ctrl_dataout = 2'd0; b_in_empty = 3'b111;
      b_in_dataout = 24'h0; b_out_full = 1'b0;
      model_reset();
      drive();
      #3;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_strobes", 32'({ctrl_read, in_read, out_write}), 0);
      chk("rst_datain", 32'(out_datain), 0);
      chk("rst_err", 32'(err_sel), 0);
      chk("b_rst_strobes", 32'({b_ctrl_read, b_in_read, b_out_write, b_busy, b_err_sel}), 0);

      // FLUX=3: out-of-range token 3 is dropped with err_sel, then token 2 transfers ch2.
      @(negedge clk);
      rst_b = 1'b1;
      b_ctrl_empty = 1'b0; b_ctrl_dataout = 2'd3; b_in_empty = 3'b011;
      b_in_dataout = {8'hC3, 8'h00, 8'h00};
      #1;
      chk("b_tok3_ctrl_read", 32'(b_ctrl_read), 1);
      chk("b_tok3_err_before", 32'(b_err_sel), 0);
      @(posedge clk); #1; b_ctrl_dataout = 2'd2;
      @(negedge clk);
      chk("b_err_set", 32'(b_err_sel), 1);
      chk("b_tok3_no_xfer", 32'({b_busy, b_out_write, b_in_read}), 0);
      chk("b_tok2_ctrl_read", 32'(b_ctrl_read), 1);
      @(posedge clk); #1; b_ctrl_empty = 1'b1;
      @(negedge clk);
      chk("b_xfer_in_read", 32'(b_in_read), 32'b100);
      chk("b_xfer_datain", 32'(b_out_datain), 32'h2C3);
      chk("b_xfer_write", 32'(b_out_write), 1);
      @(posedge clk); #1; b_in_empty = 3'b111;
      @(negedge clk);
      chk("b_after_idle", 32'({b_busy, b_out_write, b_ctrl_read, b_in_read}), 0);
      chk("b_err_sticky", 32'(b_err_sel), 1);

      // Cyclic, both channels stocked: tags 0,0,1,1,0,0 and write pattern 0,1,1 per firing.
      rst = 1'b1;
      for (int i = 0; i < 4; i++) q[0].push_back(8'(8'h10 + i));
      for (int i = 0; i < 2; i++) q[1].push_back(8'(8'h20 + i));
      wr_log.delete(); wr_pat = 0;
      for (int i = 0; i < 9; i++) step();
      exp1 = '{'h010, 'h011, 'h120, 'h121, 'h012, 'h013};
      chk("cyc_count", 32'(wr_log.size()), 6);
      for (int i = 0; i < 6 && i < wr_log.size(); i++) chk("cyc_token", 32'(wr_log[i]), 32'(exp1[i]));
      chk("cyc_wr_pattern", 32'(wr_pat & 'h1FF), 32'b011011011);

      // Channel 1 empty: stall in XFER, then 0x5A arrives.
      wr_log.delete();
      for (int i = 0; i < 4; i++) step();
      drive(); #1;
      chk("stall_busy", 32'(busy), 1);
      chk("stall_no_write", 32'(wr_log.size()), 0);
      q[1].push_back(8'h5A);
      step();
      chk("stall_release", wr_log.size() > 0 ? 32'(wr_log[0]) : 32'hDEAD, 32'h15A);
      q[1].push_back(8'h5B);
      step();

      // Control-driven: tokens 1,1,0.
      mode = 1'b1;
      cq.push_back(1); cq.push_back(1); cq.push_back(0);
      q[0].push_back(8'h11); q[1].push_back(8'h22); q[1].push_back(8'h33);
      wr_log.delete(); n_ctrl_rd = 0;
      for (int i = 0; i < 8; i++) step();
      chk("ddf_count", 32'(wr_log.size()), 3);
      exp1 = '{'h122, 'h133, 'h011, 0, 0, 0};
      for (int i = 0; i < 3 && i < wr_log.size(); i++) chk("ddf_token", 32'(wr_log[i]), 32'(exp1[i]));
      chk("ddf_ctrl_reads", 32'(n_ctrl_rd), 3);

      // Cyclic with out_full toggling every cycle: every token exactly once, in order.
      mode = 1'b0; tog_full = 1;
      for (int i = 0; i < 10; i++) begin q[0].push_back(8'(8'h40 + i)); q[1].push_back(8'(8'h80 + i)); end
      wr_log.delete();
      for (int i = 0; i < 200 && wr_log.size() < 20; i++) step();
      tog_full = 0; out_full = 1'b0;
      chk("tog_count", 32'(wr_log.size()), 20);
      for (int k = 0; k < 5; k++)
         for (int j = 0; j < 4; j++)
            if (k*4 + j < wr_log.size())
               chk("tog_order", 32'(wr_log[k*4 + j]),
                   (j < 2) ? 32'(8'h40 + 2*k + j) : 32'(9'h100 | (8'h80 + 2*k + j - 2)));

      // Reset after 1 of 2 burst tokens.
      q[0].push_back(8'h70); q[0].push_back(8'h71);
      for (int i = 0; i < 20 && !(m_busy == 1 && m_rem == 1); i++) step();
      chk("mid_burst_reached", 32'(m_busy == 1 && m_rem == 1), 1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_strobes", 32'({ctrl_read, in_read, out_write, busy}), 0);
      chk("mid_rst_datain", 32'(out_datain), 0);
`ifdef PICK_SCHED_STATS_EN
      chk("mid_rst_tok_cnt", tok_cnt, 0);
`endif
      model_reset();
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      wr_log.delete();
      for (int i = 0; i < 3; i++) step();
      chk("post_rst_count", 32'(wr_log.size()), 1);
      chk("post_rst_token", wr_log.size() > 0 ? 32'(wr_log[0]) : 32'hDEAD, 32'h071);

      // Randomised traffic with mode changes and backpressure.
      rnd_en = 1;
      for (int i = 0; i < 3000; i++) step();
      rnd_en = 0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
